pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CNT_W, default 32: width of the pulse-count request and of the remaining-pulse counter.
REQ-002 Parameter LEN_W, default 16: width of the high-phase and low-phase length fields.
REQ-003 Port clk  input  1: single clock; all logic is synchronous to its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port valid  input  1: request strobe; the request fields are sampled when valid && ready.
REQ-006 Port count  input  CNT_W: number of pulses requested; ignored when continuous=1.
REQ-007 Port high_len  input  LEN_W: high-phase length of each pulse, in cycles.
REQ-008 Port low_len  input  LEN_W: low-phase length between pulses, in cycles.
REQ-009 Port continuous  input  1: 1 selects free-running mode, which stops only on abort.
REQ-010 Port abort  input  1: terminates the active train.
REQ-011 Port ready  output  1: block is idle and can accept a request.
REQ-012 Port ack  output  1: one-cycle acknowledge of an accepted request.
REQ-013 Port pulse  output  1: registered pulse-train output.
REQ-014 Port busy  output  1: a train is in progress.
REQ-015 Port done  output  1: one-cycle strobe at train end, whether completed or aborted.
REQ-016 Port remaining  output  CNT_W: pulses not yet completed.

Function
REQ-017 The block SHALL implement three states: IDLE, HIGH and LOW; all outputs SHALL be registered.
REQ-018 In IDLE the block SHALL hold ready=1, busy=0 and pulse=0.
REQ-019 Acceptance SHALL occur on a clk edge where valid=1 and ready=1; at that edge the block SHALL latch count, high_len, low_len and continuous.
REQ-020 After the accepting edge, ack SHALL be 1 for exactly one cycle and ready SHALL be 0.
REQ-021 If count>0 or continuous=1, the block SHALL enter HIGH at the accepting edge, so pulse=1 in the cycle after acceptance (latency 1), with busy=1 and remaining=count (remaining=0 in continuous mode).
REQ-022 If count=0 and continuous=0, the block SHALL stay in IDLE, produce no pulse, and assert ack=1 and done=1 in the same single cycle with ready=1.
REQ-023 A high_len or low_len of 0 SHALL be treated as 1.
REQ-024 A phase down-counter SHALL hold pulse high for exactly high_len cycles in HIGH and low for exactly low_len cycles in LOW.
REQ-025 At the end of each HIGH phase, remaining SHALL decrement by 1 (count mode only).
REQ-026 HIGH->LOW SHALL occur when the phase expires and either remaining>1 or continuous=1.
REQ-027 LOW->HIGH SHALL occur when the LOW phase expires.
REQ-028 HIGH->IDLE SHALL occur when the phase expires with remaining=1 in count mode; no trailing low phase is inserted.
REQ-029 On HIGH->IDLE, ready=1 and done=1 SHALL appear in the first cycle after the last high cycle, with busy=0 and remaining=0.
REQ-030 abort=1 in HIGH or LOW SHALL force IDLE at that edge: next cycle pulse=0, ready=1, busy=0, done=1, and remaining holds its value.
REQ-031 abort in IDLE SHALL be ignored, including when it coincides with valid (the request is accepted).
REQ-032 abort on the same edge as a natural completion SHALL yield a single done pulse.
REQ-033 valid while ready=0 SHALL be ignored; input changes during a train SHALL have no effect.
REQ-034 A new request accepted in the same cycle that done=1 SHALL be legal and start the next train without a gap cycle beyond REQ-021.
REQ-035 Count-mode train duration SHALL be exactly count*high_len + (count-1)*low_len cycles.

Reset
REQ-036 While rst=1 at a clk edge, the block SHALL go to IDLE with ready=1, ack=0, pulse=0, busy=0, done=0, remaining=0, and the phase counter cleared.
REQ-037 Reset asserted mid-train SHALL terminate the train with no done strobe.
REQ-038 Reset SHALL take priority over valid and abort.

Verification
REQ-039 count=3, high_len=2, low_len=1 -> pulse pattern 1,1,0,1,1,0,1,1 starting 1 cycle after accept; ack in cycle 1; done and ready in cycle 9; remaining steps 3,2,1,0.
REQ-040 count=0 -> ack=1 and done=1 together for one cycle, pulse stays 0, ready never drops.
REQ-041 continuous=1, high_len=1, low_len=1, abort at cycle 20 -> pulse toggles 1,0 until the abort; next cycle pulse=0, done=1, ready=1.
REQ-042 high_len=0, low_len=0, count=2 -> pattern 1,0,1, then done.
REQ-043 count=5 with rst pulsed in the third high phase -> all outputs reach reset values the next cycle, no done; a subsequent request runs normally.
REQ-044 Back-to-back requests (valid held high with count=1 each) -> each ack follows its train's done with only the REQ-021 latency, and no pulses are lost or merged.

Source files
------------

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//
// Purpose:
//   Generates a train of pulses on request. Each pulse is high for high_len
//   cycles and is separated from the next pulse by low_len cycles. In count
//   mode the train stops after 'count' pulses, with no trailing low phase.
//   In continuous mode the train runs until aborted. A length of 0 is treated
//   as 1. All outputs are registered.
//
// Parameters:
//   CNT_W      width of the pulse-count request and remaining-pulse counter
//   LEN_W      width of the high/low phase length fields
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   valid      request strobe, accepted when valid && ready
//   count      number of pulses (ignored when continuous=1)
//   high_len   high-phase length in cycles
//   low_len    low-phase length in cycles
//   continuous 1 = free-running until abort
//   abort      terminates the active train
//   ready      idle, can accept a request
//   ack        one-cycle acknowledge of an accepted request
//   pulse      pulse-train output
//   busy       a train is in progress
//   done       one-cycle strobe at train end (completed or aborted)
//   remaining  pulses not yet completed
// -----------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic             continuous,
  input  logic             abort,
  output logic             ready,
  output logic             ack,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // Phase counter holds "cycles left in this phase minus one"; the phase
  // expires on the edge where it reads zero.
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // Latched request fields, stored as (effective length - 1) so that a
  // requested length of 0 behaves exactly like 1.
  logic [LEN_W-1:0] high_m1_q, high_m1_d;
  logic [LEN_W-1:0] low_m1_q, low_m1_d;
  logic             cont_q, cont_d;

  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] req_high_m1;
  logic [LEN_W-1:0] req_low_m1;

  assign req_high_m1 = (high_len == '0) ? '0 : (high_len - LEN_W'(1));
  assign req_low_m1  = (low_len  == '0) ? '0 : (low_len  - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    high_m1_d = high_m1_q;
    low_m1_d  = low_m1_q;
    cont_d    = cont_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        pulse_d = 1'b0;
        // abort is deliberately not looked at here: idle ignores it.
        if (valid && ready_q) begin
          high_m1_d = req_high_m1;
          low_m1_d  = req_low_m1;
          cont_d    = continuous;
          ack_d     = 1'b1;
          rem_d     = continuous ? '0 : count;
          if (continuous || (count != '0)) begin
            state_d = ST_HIGH;
            phase_d = req_high_m1;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            // Empty request: acknowledge and finish in the same cycle.
            done_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          // Abort wins over a coinciding natural end, so only one done
          // strobe is produced and remaining keeps its current value.
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (phase_q == '0) begin
          if (cont_q) begin
            state_d = ST_LOW;
            phase_d = low_m1_q;
            pulse_d = 1'b0;
          end else if (rem_q > CNT_W'(1)) begin
            state_d = ST_LOW;
            phase_d = low_m1_q;
            pulse_d = 1'b0;
            rem_d   = rem_q - CNT_W'(1);
          end else begin
            // Last pulse: return straight to idle, no trailing low phase.
            state_d = ST_IDLE;
            phase_d = '0;
            pulse_d = 1'b0;
            rem_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (phase_q == '0) begin
          state_d = ST_HIGH;
          phase_d = high_m1_q;
          pulse_d = 1'b1;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      rem_q     <= '0;
      high_m1_q <= '0;
      low_m1_q  <= '0;
      cont_q    <= 1'b0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      high_m1_q <= high_m1_d;
      low_m1_q  <= low_m1_d;
      cont_q    <= cont_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready     = ready_q;
  assign ack       = ack_q;
  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] count;
  logic [15:0] high_len;
  logic [15:0] low_len;
  logic        continuous;
  logic        abort;
  logic        ready;
  logic        ack;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [31:0] remaining;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(32), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .count      (count),
    .high_len   (high_len),
    .low_len    (low_len),
    .continuous (continuous),
    .abort      (abort),
    .ready      (ready),
    .ack        (ack),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid      = 1'b0;
    count      = '0;
    high_len   = '0;
    low_len    = '0;
    continuous = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic request(input int c, input int h, input int l, input logic cont);
    valid      = 1'b1;
    count      = c;
    high_len   = h[15:0];
    low_len    = l[15:0];
    continuous = cont;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    valid = 1'b1;   // reset must win over a request
    count = 5;
    high_len = 2;
    step();
    step();
    valid = 1'b0;
    rst = 1'b0;
    checks++;
    if ({ready, ack, pulse, busy, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got rdy/ack/pls/bsy/dn=%b expected 10000", {ready, ack, pulse, busy, done});
    end
    checks++;
    if (remaining !== 32'd0) begin
      failures++;
      $display("FAIL reset_remaining: got %0d expected 0", remaining);
    end
    $display("test_reset: ready=%b busy=%b remaining=%0d", ready, busy, remaining);
  endtask

  task automatic test_count3();
    int exp_p [1:9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
    int exp_r [1:9] = '{3, 3, 2, 2, 2, 1, 1, 1, 0};
    request(3, 2, 1, 1'b0);
    step();
    idle_inputs();
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (pulse !== exp_p[c][0]) begin
        failures++;
        $display("FAIL count3_pulse c%0d: got %b expected %0d", c, pulse, exp_p[c]);
      end
      checks++;
      if (remaining !== exp_r[c]) begin
        failures++;
        $display("FAIL count3_remaining c%0d: got %0d expected %0d", c, remaining, exp_r[c]);
      end
      checks++;
      if (ack !== (c == 1) || done !== (c == 9) || ready !== (c == 9) || busy !== (c != 9)) begin
        failures++;
        $display("FAIL count3_flags c%0d: got ack=%b done=%b ready=%b busy=%b expected ack=%0d done=%0d ready=%0d busy=%0d",
                 c, ack, done, ready, busy, (c == 1), (c == 9), (c == 9), (c != 9));
      end
      if (c < 9) step();
    end
    $display("test_count3: done=%b ready=%b remaining=%0d", done, ready, remaining);
    step();
  endtask

  task automatic test_zero_count();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready_before: got %b expected 1", ready);
    end
    request(0, 3, 3, 1'b0);
    step();
    idle_inputs();
    checks++;
    if ({ack, done, ready, pulse, busy} !== 5'b11100) begin
      failures++;
      $display("FAIL zero_accept: got ack/dn/rdy/pls/bsy=%b expected 11100", {ack, done, ready, pulse, busy});
    end
    step();
    checks++;
    if ({ack, done, ready, pulse} !== 4'b0010) begin
      failures++;
      $display("FAIL zero_after: got ack/dn/rdy/pls=%b expected 0010", {ack, done, ready, pulse});
    end
    $display("test_zero_count: ack/done single cycle, ready=%b", ready);
  endtask

  task automatic test_continuous();
    request(7, 1, 1, 1'b1);
    step();
    idle_inputs();
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (pulse !== (c % 2 == 1) || busy !== 1'b1 || remaining !== 32'd0 || ready !== 1'b0) begin
        failures++;
        $display("FAIL cont_run c%0d: got pulse=%b busy=%b rem=%0d ready=%b expected pulse=%0d busy=1 rem=0 ready=0",
                 c, pulse, busy, remaining, ready, (c % 2 == 1));
      end
      if (c < 20) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({pulse, done, ready, busy} !== 4'b0110) begin
      failures++;
      $display("FAIL cont_abort: got pls/dn/rdy/bsy=%b expected 0110", {pulse, done, ready, busy});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL cont_done_width: got %b expected 0", done);
    end
    $display("test_continuous: aborted at cycle 20");
  endtask

  task automatic test_zero_len();
    int exp_p [1:4] = '{1, 0, 1, 0};
    request(2, 0, 0, 1'b0);
    step();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (pulse !== exp_p[c][0] || done !== (c == 4) || ready !== (c == 4)) begin
        failures++;
        $display("FAIL zero_len c%0d: got pulse=%b done=%b ready=%b expected pulse=%0d done=%0d ready=%0d",
                 c, pulse, done, ready, exp_p[c], (c == 4), (c == 4));
      end
      if (c < 4) step();
    end
    $display("test_zero_len: pattern 1,0,1 then done");
    step();
  endtask

  task automatic test_reset_mid();
    request(5, 2, 1, 1'b0);
    step();
    idle_inputs();
    for (int c = 1; c < 7; c++) step();
    checks++;
    if (pulse !== 1'b1 || remaining !== 32'd3) begin
      failures++;
      $display("FAIL rstmid_pre: got pulse=%b rem=%0d expected pulse=1 rem=3", pulse, remaining);
    end
    rst = 1'b1;
    abort = 1'b1;
    step();
    rst = 1'b0;
    abort = 1'b0;
    checks++;
    if ({ready, ack, pulse, busy, done} !== 5'b10000 || remaining !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_post: got rdy/ack/pls/bsy/dn=%b rem=%0d expected 10000 rem=0", {ready, ack, pulse, busy, done}, remaining);
    end
    step();
    checks++;
    if (done !== 1'b0 || pulse !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_nodone: got done=%b pulse=%b expected 0 0", done, pulse);
    end
    request(1, 1, 1, 1'b0);
    step();
    idle_inputs();
    checks++;
    if ({ack, pulse, busy} !== 3'b111 || remaining !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_restart: got ack/pls/bsy=%b rem=%0d expected 111 rem=1", {ack, pulse, busy}, remaining);
    end
    step();
    checks++;
    if ({done, ready, pulse} !== 3'b110 || remaining !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_restart_done: got dn/rdy/pls=%b rem=%0d expected 110 rem=0", {done, ready, pulse}, remaining);
    end
    $display("test_reset_mid: reset in third high, restart ok");
    step();
  endtask

  task automatic test_abort_low();
    request(4, 1, 2, 1'b0);
    step();
    idle_inputs();
    step();   // cycle 2: first LOW cycle
    checks++;
    if (pulse !== 1'b0 || remaining !== 32'd3) begin
      failures++;
      $display("FAIL abortlow_pre: got pulse=%b rem=%0d expected 0 rem=3", pulse, remaining);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({pulse, done, ready, busy} !== 4'b0110 || remaining !== 32'd3) begin
      failures++;
      $display("FAIL abortlow_post: got pls/dn/rdy/bsy=%b rem=%0d expected 0110 rem=3", {pulse, done, ready, busy}, remaining);
    end
    $display("test_abort_low: remaining held at %0d", remaining);
    step();
  endtask

  task automatic test_abort_completion();
    request(1, 2, 1, 1'b0);
    step();
    idle_inputs();
    step();   // cycle 2: last high cycle
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({done, pulse, ready} !== 3'b101) begin
      failures++;
      $display("FAIL abortend_done: got dn/pls/rdy=%b expected 101", {done, pulse, ready});
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abortend_single: got done=%b expected 0", done);
    end
    $display("test_abort_completion: single done strobe");
  endtask

  task automatic test_abort_idle_valid();
    abort = 1'b1;
    request(1, 1, 1, 1'b0);
    step();
    idle_inputs();
    checks++;
    if ({ack, pulse, busy, done} !== 4'b1110) begin
      failures++;
      $display("FAIL abortidle_accept: got ack/pls/bsy/dn=%b expected 1110", {ack, pulse, busy, done});
    end
    step();
    $display("test_abort_idle_valid: request accepted despite abort");
    step();
  endtask

  task automatic test_ignore_valid();
    request(2, 1, 1, 1'b0);
    step();
    request(9, 5, 5, 1'b1);   // must be ignored while busy
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) idle_inputs();
      checks++;
      if (pulse !== (c % 2 == 1) || ack !== (c == 1) || done !== (c == 4)) begin
        failures++;
        $display("FAIL ignore_valid c%0d: got pulse=%b ack=%b done=%b expected pulse=%0d ack=%0d done=%0d",
                 c, pulse, ack, done, (c % 2 == 1), (c == 1), (c == 4));
      end
      if (c < 4) step();
    end
    $display("test_ignore_valid: train unaffected by inputs while busy");
    step();
  endtask

  task automatic test_back_to_back();
    int npulse = 0;
    request(1, 1, 1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 6) idle_inputs();
      if (pulse === 1'b1) npulse++;
      checks++;
      if (ack !== (c % 2 == 1) || pulse !== (c % 2 == 1) || done !== (c % 2 == 0) || ready !== (c % 2 == 0)) begin
        failures++;
        $display("FAIL b2b c%0d: got ack=%b pulse=%b done=%b ready=%b expected ack=%0d pulse=%0d done=%0d ready=%0d",
                 c, ack, pulse, done, ready, (c % 2 == 1), (c % 2 == 1), (c % 2 == 0), (c % 2 == 0));
      end
    end
    step();
    checks++;
    if ({ack, pulse, ready} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_end: got ack/pls/rdy=%b expected 001", {ack, pulse, ready});
    end
    checks++;
    if (npulse !== 3) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d expected 3", npulse);
    end
    $display("test_back_to_back: %0d trains", npulse);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_count3();
    test_zero_count();
    test_continuous();
    test_zero_len();
    test_reset_mid();
    test_abort_low();
    test_abort_completion();
    test_abort_idle_valid();
    test_ignore_valid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
